// File: rtl/fifo_sync_flags_pkg.sv
// fifo_sync_flags_pkg
//   Shared FIFO constants. Holds only the read-mode encodings used by the
//   FWFT parameter of fifo_sync_flags; no types live here.
package fifo_sync_flags_pkg;

  localparam int FWFT_OFF = 0;  // registered-read: pop loads data_out at the edge
  localparam int FWFT_ON  = 1;  // first-word-fall-through: head word always visible

endpackage

// File: rtl/fifo_sync_flags_mem.sv
// fifo_sync_flags_mem
//   Dual-port storage array for fifo_sync_flags: synchronous write,
//   combinational (asynchronous) read. Contents are not reset.
// Ports:
//   clk         rising-edge clock
//   wr_en       write strobe, stores wr_data at wr_addr on the edge
//   wr_addr     write address
//   wr_data     write data
//   rd_addr     read address
//   rd_data     read data, combinational from rd_addr
module fifo_sync_flags_mem #(
  parameter int ADDR_LENGTH = 8,
  parameter int WORD_LENGTH = 8
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [ADDR_LENGTH-1:0] wr_addr,
  input  logic [WORD_LENGTH-1:0] wr_data,
  input  logic [ADDR_LENGTH-1:0] rd_addr,
  output logic [WORD_LENGTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_LENGTH;

  logic [WORD_LENGTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fifo_sync_flags.sv
// fifo_sync_flags
//   Synchronous FIFO with occupancy count, full/empty, almost-full/almost-empty
//   status and one-cycle overflow/underflow error pulses. Read side is either
//   registered (FWFT_OFF) or first-word-fall-through (FWFT_ON).
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   data_in          write data
//   write_en         push request (accepted when not full)
//   read_en          pop request (accepted when not empty)
//   data_out, valid  read data and its qualifier
//   full, empty      occupancy == DEPTH / == 0
//   almost_full      count >= AF_THR
//   almost_empty     count <= AE_THR
//   count            occupancy 0..DEPTH
//   overflow         one-cycle pulse after a rejected push
//   underflow        one-cycle pulse after a rejected pop
module fifo_sync_flags
  import fifo_sync_flags_pkg::*;
#(
  parameter int ADDR_LENGTH = 8,
  parameter int WORD_LENGTH = 8,
  parameter int FWFT        = FWFT_OFF,
  parameter int AF_THR      = (1 << ADDR_LENGTH) - 2,
  parameter int AE_THR      = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WORD_LENGTH-1:0] data_in,
  input  logic                   write_en,
  input  logic                   read_en,
  output logic [WORD_LENGTH-1:0] data_out,
  output logic                   valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [ADDR_LENGTH:0]   count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int DEPTH = 1 << ADDR_LENGTH;
  localparam logic [ADDR_LENGTH:0] DEPTH_C  = (ADDR_LENGTH+1)'(DEPTH);
  localparam logic [ADDR_LENGTH:0] AF_THR_C = (ADDR_LENGTH+1)'(AF_THR);
  localparam logic [ADDR_LENGTH:0] AE_THR_C = (ADDR_LENGTH+1)'(AE_THR);
  localparam logic [ADDR_LENGTH:0] PTR_INC  = 1;

  if (AF_THR > DEPTH || AE_THR >= DEPTH || AF_THR < 0 || AE_THR < 0) begin : g_bad_thr
    $error("fifo_sync_flags: AF_THR must be <= DEPTH and AE_THR must be < DEPTH");
  end

  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [ADDR_LENGTH:0]   w_ptr_q, w_ptr_d;
  logic [ADDR_LENGTH:0]   r_ptr_q, r_ptr_d;
  logic                   overflow_q, underflow_q;
  logic                   push_ok, pop_ok;
  logic [WORD_LENGTH-1:0] rd_data;

  assign count        = w_ptr_q - r_ptr_q;
  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_full  = (count >= AF_THR_C);
  assign almost_empty = (count <= AE_THR_C);

  // Acceptance uses the pre-edge flags only: a pop never makes room for a
  // push in the same cycle, and a push never feeds a pop in the same cycle.
  assign push_ok = write_en & ~full;
  assign pop_ok  = read_en & ~empty;

  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    if (push_ok) w_ptr_d = w_ptr_q + PTR_INC;
    if (pop_ok)  r_ptr_d = r_ptr_q + PTR_INC;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      overflow_q  <= write_en & full;
      underflow_q <= read_en & empty;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  fifo_sync_flags_mem #(
    .ADDR_LENGTH (ADDR_LENGTH),
    .WORD_LENGTH (WORD_LENGTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push_ok & ~reset),
    .wr_addr (w_ptr_q[ADDR_LENGTH-1:0]),
    .wr_data (data_in),
    .rd_addr (r_ptr_q[ADDR_LENGTH-1:0]),
    .rd_data (rd_data)
  );

  if (FWFT == FWFT_ON) begin : g_fwft
    // Head word is shown directly; zero while empty so reset leaves data_out at 0.
    assign data_out = empty ? '0 : rd_data;
    assign valid    = ~empty;
  end else begin : g_reg
    logic [WORD_LENGTH-1:0] data_out_q;
    logic                   valid_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        data_out_q <= '0;
        valid_q    <= 1'b0;
      end else begin
        if (pop_ok) data_out_q <= rd_data;
        valid_q <= pop_ok;
      end
    end

    assign data_out = data_out_q;
    assign valid    = valid_q;
  end

endmodule

// File: tb/tb_fifo_sync_flags.sv
module tb_fifo_sync_flags;
  import fifo_sync_flags_pkg::*;

  localparam int AW    = 2;
  localparam int WW    = 8;
  localparam int DEPTH = 1 << AW;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [WW-1:0] data_in = '0;
  logic          write_en = 1'b0;
  logic          read_en = 1'b0;

  logic [WW-1:0] dout0, dout1;
  logic          valid0, valid1, full0, full1, empty0, empty1;
  logic          af0, af1, ae0, ae1, ovf0, ovf1, unf0, unf1;
  logic [AW:0]   count0, count1;

  always #5 clk = ~clk;

  fifo_sync_flags #(
    .ADDR_LENGTH (AW), .WORD_LENGTH (WW), .FWFT (FWFT_OFF), .AF_THR (AF), .AE_THR (AE)
  ) u_dut_reg (
    .clk (clk), .reset (reset), .data_in (data_in), .write_en (write_en), .read_en (read_en),
    .data_out (dout0), .valid (valid0), .full (full0), .empty (empty0),
    .almost_full (af0), .almost_empty (ae0), .count (count0),
    .overflow (ovf0), .underflow (unf0)
  );

  fifo_sync_flags #(
    .ADDR_LENGTH (AW), .WORD_LENGTH (WW), .FWFT (FWFT_ON), .AF_THR (AF), .AE_THR (AE)
  ) u_dut_fwft (
    .clk (clk), .reset (reset), .data_in (data_in), .write_en (write_en), .read_en (read_en),
    .data_out (dout1), .valid (valid1), .full (full1), .empty (empty1),
    .almost_full (af1), .almost_empty (ae1), .count (count1),
    .overflow (ovf1), .underflow (unf1)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: a plain queue of words plus the registered-read output.
  logic [WW-1:0] model_q[$];
  logic [WW-1:0] m_dout;
  logic          m_valid;
  logic          m_ovf;
  logic          m_unf;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string ph);
    int sz;
    sz = model_q.size();
    check_val({ph, " count_reg"},  32'(count0), 32'(sz));
    check_val({ph, " count_fwft"}, 32'(count1), 32'(sz));
    check_val({ph, " empty"},  {30'b0, empty1, empty0},  {30'b0, sz == 0, sz == 0});
    check_val({ph, " full"},   {30'b0, full1, full0},    {30'b0, sz == DEPTH, sz == DEPTH});
    check_val({ph, " afull"},  {30'b0, af1, af0},        {30'b0, sz >= AF, sz >= AF});
    check_val({ph, " aempty"}, {30'b0, ae1, ae0},        {30'b0, sz <= AE, sz <= AE});
    check_val({ph, " ovf"},    {30'b0, ovf1, ovf0},      {30'b0, m_ovf, m_ovf});
    check_val({ph, " unf"},    {30'b0, unf1, unf0},      {30'b0, m_unf, m_unf});
    check_val({ph, " valid_reg"},  32'(valid0), 32'(m_valid));
    check_val({ph, " dout_reg"},   32'(dout0),  32'(m_dout));
    check_val({ph, " valid_fwft"}, 32'(valid1), 32'(sz != 0));
    if (sz != 0) check_val({ph, " dout_fwft"}, 32'(dout1), 32'(model_q[0]));
  endtask

  // One clock cycle: drive inputs, advance the model on the edge, check after it.
  task automatic step(input string ph, input logic we, input logic re,
                      input logic [WW-1:0] din, input logic rst);
    int  sz;
    bit  push_ok, pop_ok;
    sz       = model_q.size();
    write_en = we;
    read_en  = re;
    data_in  = din;
    reset    = rst;
    @(posedge clk);
    if (rst) begin
      model_q.delete();
      m_dout  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
    end else begin
      push_ok = we && (sz != DEPTH);
      pop_ok  = re && (sz != 0);
      m_ovf   = we && (sz == DEPTH);
      m_unf   = re && (sz == 0);
      m_valid = pop_ok;
      if (pop_ok) m_dout = model_q.pop_front();
      if (push_ok) model_q.push_back(din);
    end
    #1;
    check_all(ph);
  endtask

  initial begin
    logic [WW-1:0] w;
    m_dout = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;

    step("reset", 1'b1, 1'b1, 8'h33, 1'b1);
    step("idle", 1'b0, 1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 4; i++) step("fill", 1'b1, 1'b0, 8'hA1 + 8'(i), 1'b0);
    step("full_push_pop", 1'b1, 1'b1, 8'hFF, 1'b0);
    step("ovf_clear", 1'b0, 1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 3; i++) step("drain", 1'b0, 1'b1, 8'h00, 1'b0);
    step("empty_pop", 1'b0, 1'b1, 8'h00, 1'b0);
    step("empty_push_pop", 1'b1, 1'b1, 8'h11, 1'b0);
    step("unf_clear", 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) begin
      w = 8'($urandom);
      step("wrap_pair", 1'b1, 1'b1, w, 1'b0);
    end
    step("wrap_tail", 1'b0, 1'b1, 8'h00, 1'b0);

    step("fwft_push", 1'b1, 1'b0, 8'h5C, 1'b0);
    step("fwft_pop", 1'b0, 1'b1, 8'h00, 1'b0);

    for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 1'b0, 8'hC0 + 8'(i), 1'b0);
    step("mid_rst", 1'b1, 1'b1, 8'hEE, 1'b1);
    step("post_rst", 1'b0, 1'b0, 8'h00, 1'b0);

    // Random phases bias toward filling, draining, and balanced traffic.
    for (int ph = 0; ph < 12; ph++) begin
      int wp, rp;
      case (ph % 3)
        0: begin wp = 80; rp = 30; end
        1: begin wp = 30; rp = 80; end
        default: begin wp = 60; rp = 60; end
      endcase
      for (int i = 0; i < 150; i++) begin
        logic we, re, rs;
        we = ($urandom_range(99) < wp);
        re = ($urandom_range(99) < rp);
        rs = ($urandom_range(199) == 0);
        step("rand", we, re, 8'($urandom), rs);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
